// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register/flag scoreboard.
package reg_scoreboard_pkg;

   localparam int NUM_REGS         = 4;
   localparam int REG_AW           = 2;
   localparam int MAX_INFLIGHT_DEF = 3;
   localparam int CNT_W_DEF        = 2;

   typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// In-flight write counter: saturating inc/dec with a clear that wins over both.
// err_o pulses for one cycle on an overflow or underflow attempt.
module sb_counter #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         dec_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o,
   output logic         err_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear first, then a matched inc/dec pair cancels, else saturate.
   always_comb begin
      cnt_d = cnt_q;
      err_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !dec_i) begin
         if (cnt_q == MAX_V) err_o = 1'b1;
         else                cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0)    err_o = 1'b1;
         else                cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register and Z/N flag scoreboard beside decode. Holds an instruction while
// any source it reads still has a pending writer; releases on retire.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int STALL_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_AW-1:0]   src1,
   input  logic [REG_AW-1:0]   src2,
   input  logic                src1_en,
   input  logic                src2_en,
   input  logic [REG_AW-1:0]   dest,
   input  logic                wb_en_id,
   input  logic                s_id,
   input  logic                flag_use,
   input  logic                writeBackEn,
   input  logic [REG_AW-1:0]   Dest_wb,
   input  logic                flag_upd,
   input  logic                flush,
   output logic                hazard,
   output logic [NUM_REGS-1:0] busy,
   output logic                flags_busy,
   output logic [STALL_W-1:0]  stall_cnt,
   output logic                err
);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [CNT_W-1:0]               fcnt;
   logic [NUM_REGS-1:0]            cnt_nz;
   logic [NUM_REGS:0]              err_pls;
   logic                           iss;

   logic [NUM_REGS-1:0] busy_q;
   logic                flags_busy_q;
   logic [STALL_W-1:0]  stall_q;
   logic                err_q;

   // Same-cycle hazard: no bypass, so a register retiring this cycle still stalls.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) cnt_nz[r] = (cnt[r] != '0);
      hazard = id_valid & ((src1_en & cnt_nz[src1]) |
                           (src2_en & cnt_nz[src2]) |
                           (flag_use & (fcnt != '0)));
      iss    = id_valid & ~hazard;
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      sb_counter #(.W(CNT_W), .MAX(MAX_INFLIGHT)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc_i (iss & wb_en_id & (dest == REG_AW'(r))),
         .dec_i (writeBackEn & (Dest_wb == REG_AW'(r))),
         .clr_i (flush),
         .cnt_o (cnt[r]),
         .err_o (err_pls[r])
      );
   end

   sb_counter #(.W(CNT_W), .MAX(MAX_INFLIGHT)) u_fcnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (iss & s_id),
      .dec_i (flag_upd),
      .clr_i (flush),
      .cnt_o (fcnt),
      .err_o (err_pls[NUM_REGS])
   );

   // Registered busy decode, saturating stall statistics and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q       <= '0;
         flags_busy_q <= 1'b0;
         stall_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         busy_q       <= cnt_nz;
         flags_busy_q <= (fcnt != '0);
         if (hazard && (stall_q != '1)) stall_q <= stall_q + 1'b1;
         err_q        <= err_q | (|err_pls);
      end
   end

   assign busy       = busy_q;
   assign flags_busy = flags_busy_q;
   assign stall_cnt  = stall_q;
   assign err        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random
// traffic compared against a counting model of in-flight writers.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, src1_en, src2_en, wb_en_id, s_id, flag_use;
   logic        writeBackEn, flag_upd, flush;
   logic [1:0]  src1, src2, dest, Dest_wb;
   logic        hazard, flags_busy, err;
   logic [3:0]  busy;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   // reference model: number of outstanding writers per register / flag set
   int   m_cnt[4];
   int   m_fcnt;
   int   m_stall;
   bit   m_err;
   logic [3:0] m_busy;
   bit   m_fbusy;
   bit   obs_hz, exp_hz;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
      .src1_en(src1_en), .src2_en(src2_en), .dest(dest), .wb_en_id(wb_en_id),
      .s_id(s_id), .flag_use(flag_use), .writeBackEn(writeBackEn),
      .Dest_wb(Dest_wb), .flag_upd(flag_upd), .flush(flush), .hazard(hazard),
      .busy(busy), .flags_busy(flags_busy), .stall_cnt(stall_cnt), .err(err)
   );

   task automatic clear_in();
      id_valid = 0; src1 = 0; src2 = 0; src1_en = 0; src2_en = 0; dest = 0;
      wb_en_id = 0; s_id = 0; flag_use = 0; writeBackEn = 0; Dest_wb = 0;
      flag_upd = 0; flush = 0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 4; r++) m_cnt[r] = 0;
      m_fcnt = 0; m_stall = 0; m_err = 0; m_busy = 0; m_fbusy = 0;
   endtask

   function automatic bit model_hz();
      return id_valid && ((src1_en && m_cnt[src1] != 0) ||
                          (src2_en && m_cnt[src2] != 0) ||
                          (flag_use && m_fcnt != 0));
   endfunction

   // apply one net change (+1 / -1 / 0) to a counter of pending writers
   task automatic bump(inout int c, input int net);
      if (net > 0) begin
         if (c == 3) m_err = 1; else c++;
      end else if (net < 0) begin
         if (c == 0) m_err = 1; else c--;
      end
   endtask

   task automatic model_edge(input bit hz);
      bit iss;
      int net;
      iss = id_valid && !hz;
      for (int r = 0; r < 4; r++) m_busy[r] = (m_cnt[r] != 0);
      m_fbusy = (m_fcnt != 0);
      if (hz && m_stall < 65535) m_stall++;
      if (flush) begin
         for (int r = 0; r < 4; r++) m_cnt[r] = 0;
         m_fcnt = 0;
      end else begin
         for (int r = 0; r < 4; r++) begin
            net = int'(iss && wb_en_id && dest == 2'(r)) - int'(writeBackEn && Dest_wb == 2'(r));
            bump(m_cnt[r], net);
         end
         net = int'(iss && s_id) - int'(flag_upd);
         bump(m_fcnt, net);
      end
   endtask

   // inputs already set at posedge+1: sample hazard, advance model and clock
   task automatic step();
      #1;
      obs_hz = hazard;
      exp_hz = model_hz();
      model_edge(exp_hz);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   task automatic test_reset();
      id_valid = 1; src1_en = 1; src2_en = 1; flag_use = 1; src1 = 2; src2 = 3;
      #1;
      checks++; if (hazard !== 1'b0)     begin errors++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
      checks++; if (busy !== 4'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0000", busy); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL reset_fbusy got=%b exp=0", flags_busy); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      id_valid = 1; wb_en_id = 1; dest = 2; step();
      checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL raw_issue hz got=%b exp=0", obs_hz); end
      clear_in(); id_valid = 1; src1_en = 1; src1 = 2; step();
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL raw_stall hz got=%b exp=1", obs_hz); end
      checks++; if (busy !== 4'b0100) begin errors++; $display("FAIL raw_busy got=%b exp=0100", busy); end
      step();
      writeBackEn = 1; Dest_wb = 2; step();
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL raw_nobypass hz got=%b exp=1", obs_hz); end
      writeBackEn = 0; step();
      checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL raw_release hz got=%b exp=0", obs_hz); end
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_stallcnt got=%0d exp=3", stall_cnt); end
      checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL raw_busy_clr got=%b exp=0000", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL raw_err got=%b exp=0", err); end
   endtask

   task automatic test_overflow();
      do_reset();
      id_valid = 1; wb_en_id = 1; dest = 1;
      repeat (3) step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_pre_err got=%b exp=0", err); end
      step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", err); end
      clear_in(); writeBackEn = 1; Dest_wb = 1;
      repeat (2) step();
      id_valid = 1; src1_en = 1; src1 = 1; step();
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL ovf_sat_hold hz got=%b exp=1", obs_hz); end
      writeBackEn = 0; step();
      checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL ovf_sat_drain hz got=%b exp=0", obs_hz); end
      clear_in(); repeat (2) step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", err); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      id_valid = 1; wb_en_id = 1; dest = 3; step();
      src1_en = 1; src1 = 0; writeBackEn = 1; Dest_wb = 3; step();
      checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL same_nonr3 hz got=%b exp=0", obs_hz); end
      clear_in(); id_valid = 1; src2_en = 1; src2 = 3; step();
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL same_r3_held hz got=%b exp=1", obs_hz); end
      checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL same_busy got=%b exp=1000", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL same_err got=%b exp=0", err); end
   endtask

   task automatic test_flags();
      do_reset();
      id_valid = 1; s_id = 1; step();
      clear_in(); id_valid = 1; flag_use = 1; step();
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL flag_stall hz got=%b exp=1", obs_hz); end
      step();
      checks++; if (flags_busy !== 1'b1) begin errors++; $display("FAIL flag_busy got=%b exp=1", flags_busy); end
      flag_upd = 1; step();
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL flag_upd_cycle hz got=%b exp=1", obs_hz); end
      flag_upd = 0; step();
      checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL flag_release hz got=%b exp=0", obs_hz); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL flag_busy_clr got=%b exp=0", flags_busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL flag_err got=%b exp=0", err); end
   endtask

   task automatic test_flush();
      do_reset();
      writeBackEn = 1; Dest_wb = 3; step();   // underflow to set err beforehand
      clear_in(); id_valid = 1; wb_en_id = 1; dest = 0; s_id = 1; step();
      s_id = 0; step();
      clear_in(); flush = 1; writeBackEn = 1; Dest_wb = 0; flag_upd = 1;
      id_valid = 1; wb_en_id = 1; dest = 1; step();
      checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL flush_busy_lag got=%b exp=0001", busy); end
      clear_in(); id_valid = 1; src1_en = 1; src1 = 0; src2_en = 1; src2 = 1; flag_use = 1; step();
      checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL flush_clear hz got=%b exp=0", obs_hz); end
      checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL flush_busy got=%b exp=0000", busy); end
      checks++; if (flags_busy !== 1'b0) begin errors++; $display("FAIL flush_fbusy got=%b exp=0", flags_busy); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_err_kept got=%b exp=1", err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      writeBackEn = 1; Dest_wb = 0; step();   // err=1 before the reset pulse
      clear_in(); id_valid = 1; wb_en_id = 1; dest = 2; step();
      clear_in(); id_valid = 1; src1_en = 1; src1 = 2; step();
      step();
      #2 rst = 1;
      #1;
      checks++; if (hazard !== 1'b0)     begin errors++; $display("FAIL rstmid_hazard got=%b exp=0", hazard); end
      checks++; if (busy !== 4'b0)       begin errors++; $display("FAIL rstmid_busy got=%b exp=0000", busy); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_stall got=%0d exp=0", stall_cnt); end
      checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rstmid_err got=%b exp=0", err); end
      model_reset();
      @(posedge clk); #1 rst = 0;
      clear_in(); writeBackEn = 1; Dest_wb = 2; step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rstmid_underflow got=%b exp=1", err); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         id_valid = ($urandom % 4) != 0;
         src1 = 2'($urandom); src2 = 2'($urandom); dest = 2'($urandom);
         src1_en = $urandom % 2; src2_en = $urandom % 2;
         wb_en_id = $urandom % 2; s_id = ($urandom % 4) == 0; flag_use = ($urandom % 4) == 0;
         Dest_wb = 2'($urandom);
         writeBackEn = (m_cnt[Dest_wb] != 0) ? 1'($urandom % 2) : 1'(($urandom % 40) == 0);
         flag_upd    = (m_fcnt != 0) ? 1'($urandom % 2) : 1'(($urandom % 40) == 0);
         flush = ($urandom % 25) == 0;
         step();
         checks++; if (obs_hz !== exp_hz) begin errors++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", i, obs_hz, exp_hz); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_busy); end
         checks++; if (flags_busy !== m_fbusy) begin errors++; $display("FAIL rnd_fbusy cyc=%0d got=%b exp=%b", i, flags_busy, m_fbusy); end
         checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_stall); end
         checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, err, m_err); end
      end
   endtask

   task automatic test_stall_sat();
      do_reset();
      id_valid = 1; wb_en_id = 1; dest = 0; step();
      clear_in(); id_valid = 1; src1_en = 1; src1 = 0;
      repeat (65540) step();
      checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got=%0d exp=65535", stall_cnt); end
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL stall_sat_hz got=%b exp=1", obs_hz); end
   endtask

   initial begin
      rst = 1;
      clear_in();
      model_reset();
      test_reset();
      @(posedge clk); #1 rst = 0;
      clear_in();
      test_raw_hazard();
      test_overflow();
      test_same_cycle();
      test_flags();
      test_flush();
      test_reset_mid();
      test_random();
      test_stall_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
